banco_registros: RTL and testbench
==================================

Name: banco_registros

Overview:
- RV32I integer register file: 32 × 32-bit registers (x0..x31), two read ports and one write port.
- Sits directly upstream of the execute-stage ALU and supplies its a/b operands; the writeback value (ALU result or load data) returns on the write port.
- Reads are registered (one-cycle latency, block-RAM style) with a write-to-read bypass, and a read-hold (stall) input.
- Storage is not reset in parallel: after reset, an internal sweep FSM clears x1..x31 one per cycle, and `listo` reports when the file is usable.

Parameters:
- ANCHO, 32, data width of each register.
- N_REG, 32, number of registers (power of two; address width = log2(N_REG)).
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to the read output; 0 = old contents are returned.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- habilitar  input  1  1 = read registers update this edge; 0 = rd1/rd2 hold (pipeline stall).
- rs1  input  5  read address, port 1.
- rs2  input  5  read address, port 2.
- we  input  1  write enable.
- rd  input  5  write address.
- wd  input  ANCHO  write data.
- rd1  output  ANCHO  registered read data, port 1 (feeds ALU a).
- rd2  output  ANCHO  registered read data, port 2 (feeds ALU b).
- listo  output  1  1 = clearing finished, file operational.

Behaviour:
- Reset: one clock, clk. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Edge with reset=1: estado←LIMPIANDO, contador←1, rd1←0, rd2←0, listo←0. Array contents are not touched on this edge.
- States: LIMPIANDO, OPERATIVO.
- LIMPIANDO, each edge with reset=0:
  - mem[contador]←0, contador←contador+1.
  - When the written index is N_REG-1: estado←OPERATIVO and listo←1 on that same edge.
  - listo therefore rises on the 31st edge after reset deasserts.
  - we is ignored and no user write occurs.
  - rd1/rd2 are forced to 0 regardless of habilitar.
- OPERATIVO, edge with we=1 and rd≠0: mem[rd]←wd. Writes to x0 are discarded.
- OPERATIVO, edge with habilitar=1:
  - rd1←val(rs1), rd2←val(rs2); latency is one cycle from the address to the data.
  - val(x0) is always 0.
  - If BYPASS=1, we=1, rd=rsN and rd≠0, then val=wd (new data).
  - Otherwise val=mem[rsN], i.e. contents before this edge's write.
- OPERATIVO, habilitar=0: rd1/rd2 hold their values. Writes still occur. The held output is not refreshed by a write to the same address.
- rs1=rs2: both ports return the identical value.
- Reset mid-sweep or during OPERATIVO: restart the sweep from contador=1 and drop listo the same edge. Any in-flight write on that edge is discarded.
- x0 is never stored. No read or write path can make it nonzero.
- Address width is fixed at 5 for N_REG=32. The counter wraps are unreachable because the FSM exits at N_REG-1.

Test Plan:
- Reset sweep:
  - Stimulus: reset high 2 cycles, then low, with we=1, rd=5, wd=0xDEADBEEF held throughout.
  - Required: listo=0 for 30 edges and 1 on the 31st.
  - Required: a read of x5 after listo then returns 0, because the write was ignored during the sweep.
- Basic write/read:
  - Stimulus: write x3=0x12345678, then next cycle rs1=3, rs2=0.
  - Required: one cycle later rd1=0x12345678, rd2=0.
- x0 protection: write rd=0, wd=0xFFFFFFFF; then read rs1=0 → rd1=0.
- Bypass:
  - Stimulus: same edge we=1, rd=7, wd=0xA5A5A5A5, rs1=7, rs2=7.
  - Required: BYPASS=1 → rd1=rd2=0xA5A5A5A5.
  - Required: BYPASS=0 → both return the old x7 value.
- Stall:
  - Stimulus: rd1 shows x4=0x11; set habilitar=0, write x4=0x22, rs1=4 for 3 cycles.
  - Required: rd1 stays 0x11; after habilitar=1 the next edge gives rd1=0x22.
- Reset mid-operation:
  - Stimulus: after writing x31=0x55, assert reset for 1 cycle at sweep index 10.
  - Required: listo drops immediately, then rises again 31 edges after release; x31 then reads 0.

Source files
------------

// File: rtl/banco_registros.sv
// RV32I integer register file: N_REG x ANCHO, two registered read ports with
// optional write-to-read forwarding, read-hold input and a post-reset clear sweep.

// One registered read port: x0 reads as zero, optional forwarding of the
// write port, output cleared during reset and the clear sweep.
module banco_puerto_lectura #(
    parameter int ANCHO  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             limpiando,
    input  logic             habilitar,
    input  logic [AW-1:0]    rs,
    input  logic [ANCHO-1:0] mem_dato,
    input  logic             we,
    input  logic [AW-1:0]    rd,
    input  logic [ANCHO-1:0] wd,
    output logic [ANCHO-1:0] dato
);
    logic [ANCHO-1:0] val;

    // Select the value to capture: zero register, forwarded write, or array contents
    always_comb begin
        val = mem_dato;
        if (rs == '0)
            val = '0;
        else if ((BYPASS != 0) && we && (rd == rs))
            val = wd;
    end

    // Output register: zero while not operational, holds when habilitar is low
    always_ff @(posedge clk) begin
        if (reset || limpiando)
            dato <= '0;
        else if (habilitar)
            dato <= val;
    end
endmodule

module banco_registros #(
    parameter int ANCHO  = 32,
    parameter int N_REG  = 32,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     habilitar,
    input  logic [$clog2(N_REG)-1:0] rs1,
    input  logic [$clog2(N_REG)-1:0] rs2,
    input  logic                     we,
    input  logic [$clog2(N_REG)-1:0] rd,
    input  logic [ANCHO-1:0]         wd,
    output logic [ANCHO-1:0]         rd1,
    output logic [ANCHO-1:0]         rd2,
    output logic                     listo
);
    localparam int AW = $clog2(N_REG);
    localparam int NUM_PUERTOS = 2;

    typedef enum logic {LIMPIANDO = 1'b0, OPERATIVO = 1'b1} estado_t;

    estado_t          estado, estado_sig;
    logic [AW-1:0]    contador;
    logic             limpiando;
    logic [ANCHO-1:0] mem [N_REG];

    logic [NUM_PUERTOS-1:0][AW-1:0]    rs_vec;
    logic [NUM_PUERTOS-1:0][ANCHO-1:0] mem_dato;
    logic [NUM_PUERTOS-1:0][ANCHO-1:0] dato;

    // State register: reset always restarts the clear sweep
    always_ff @(posedge clk) begin
        if (reset)
            estado <= LIMPIANDO;
        else
            estado <= estado_sig;
    end

    // Next state: leave the sweep on the edge that clears the last register
    always_comb begin
        estado_sig = estado;
        if (estado == LIMPIANDO && contador == AW'(N_REG - 1))
            estado_sig = OPERATIVO;
    end

    // Outputs decoded from state; listo rises on the same edge as the last clear
    always_comb begin
        limpiando = (estado == LIMPIANDO);
        listo     = (estado == OPERATIVO);
    end

    // Sweep index; x0 is never stored, so clearing starts at x1
    always_ff @(posedge clk) begin
        if (reset)
            contador <= AW'(1);
        else if (limpiando)
            contador <= contador + AW'(1);
    end

    // Array write: sweep clears, user writes only once operational, x0 discarded
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (limpiando)
                mem[contador] <= '0;
            else if (we && rd != '0)
                mem[rd] <= wd;
        end
    end

    assign rs_vec = {rs2, rs1};

    for (genvar p = 0; p < NUM_PUERTOS; p++) begin : g_puerto
        assign mem_dato[p] = mem[rs_vec[p]];

        banco_puerto_lectura #(
            .ANCHO (ANCHO),
            .AW    (AW),
            .BYPASS(BYPASS)
        ) u_puerto (
            .clk      (clk),
            .reset    (reset),
            .limpiando(limpiando),
            .habilitar(habilitar),
            .rs       (rs_vec[p]),
            .mem_dato (mem_dato[p]),
            .we       (we),
            .rd       (rd),
            .wd       (wd),
            .dato     (dato[p])
        );
    end

    assign rd1 = dato[0];
    assign rd2 = dato[1];
endmodule

// File: tb/tb_banco_registros.sv
// Bench for banco_registros: one DUT with forwarding, one without, same stimulus,
// checked against an array-based model of the register file.
module tb_banco_registros;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        habilitar = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
    logic        listo_b1, listo_b0;

    int errores = 0;
    int checks  = 0;

    // model state
    logic [31:0] ref_mem [32];
    logic [31:0] ref_o   [2][2];   // [bypass][port]
    bit          ref_listo;
    bit          barrido;
    int          idx;

    always #5 clk = ~clk;

    banco_registros #(.ANCHO(32), .N_REG(32), .BYPASS(1)) dut_b1 (
        .clk(clk), .reset(reset), .habilitar(habilitar), .rs1(rs1), .rs2(rs2),
        .we(we), .rd(rd), .wd(wd), .rd1(rd1_b1), .rd2(rd2_b1), .listo(listo_b1));

    banco_registros #(.ANCHO(32), .N_REG(32), .BYPASS(0)) dut_b0 (
        .clk(clk), .reset(reset), .habilitar(habilitar), .rs1(rs1), .rs2(rs2),
        .we(we), .rd(rd), .wd(wd), .rd1(rd1_b0), .rd2(rd2_b0), .listo(listo_b0));

    // One clock edge; model applies the behavioural rules with the inputs present at the edge
    task automatic ciclo();
        logic [4:0] a;
        @(posedge clk);
        if (reset) begin
            barrido = 1; idx = 1; ref_listo = 0;
            for (int b = 0; b < 2; b++) for (int p = 0; p < 2; p++) ref_o[b][p] = '0;
        end else if (barrido) begin
            ref_mem[idx] = '0;
            if (idx == 31) begin barrido = 0; ref_listo = 1; end
            idx++;
            for (int b = 0; b < 2; b++) for (int p = 0; p < 2; p++) ref_o[b][p] = '0;
        end else begin
            if (habilitar)
                for (int b = 0; b < 2; b++)
                    for (int p = 0; p < 2; p++) begin
                        a = (p == 0) ? rs1 : rs2;
                        if (a == 0) ref_o[b][p] = '0;
                        else if (b == 1 && we && rd == a) ref_o[b][p] = wd;
                        else ref_o[b][p] = ref_mem[a];
                    end
            if (we && rd != 0) ref_mem[rd] = wd;
        end
        #1;
    endtask

    task automatic escribir(input logic [4:0] r, input logic [31:0] d);
        we = 1; rd = r; wd = d; habilitar = 1;
        ciclo();
        we = 0;
    endtask

    task automatic test_reset();
        reset = 1; we = 1; rd = 5; wd = 32'hDEADBEEF; habilitar = 1; rs1 = 5; rs2 = 5;
        ciclo(); ciclo();
        checks++;
        if (listo_b1 !== 1'b0 || rd1_b1 !== 32'h0) begin
            errores++; $display("FAIL reset_state listo=%b rd1=%h required listo=0 rd1=0", listo_b1, rd1_b1);
        end
        reset = 0;
        for (int i = 1; i <= 31; i++) begin
            ciclo();
            checks++;
            if (listo_b1 !== (i == 31) || listo_b0 !== (i == 31)) begin
                errores++; $display("FAIL sweep_listo edge=%0d got=%b/%b required=%b", i, listo_b1, listo_b0, i == 31);
            end
        end
        we = 0; rs1 = 5; rs2 = 5;
        ciclo();
        checks++;
        if (rd1_b1 !== 32'h0 || rd2_b1 !== 32'h0) begin
            errores++; $display("FAIL sweep_ignores_write rd1=%h rd2=%h required 0", rd1_b1, rd2_b1);
        end
    endtask

    task automatic test_basico();
        escribir(3, 32'h12345678);
        rs1 = 3; rs2 = 0;
        ciclo();
        checks++;
        if (rd1_b1 !== 32'h12345678 || rd2_b1 !== 32'h0 || rd1_b0 !== 32'h12345678) begin
            errores++; $display("FAIL basic_rw rd1=%h rd2=%h rd1(nobyp)=%h required 12345678/0", rd1_b1, rd2_b1, rd1_b0);
        end
    endtask

    task automatic test_x0();
        rs1 = 0; rs2 = 0;
        escribir(0, 32'hFFFFFFFF);
        checks++;
        if (rd1_b1 !== 32'h0 || rd1_b0 !== 32'h0) begin
            errores++; $display("FAIL x0_bypass rd1=%h/%h required 0", rd1_b1, rd1_b0);
        end
        ciclo();
        checks++;
        if (rd1_b1 !== 32'h0 || rd2_b0 !== 32'h0) begin
            errores++; $display("FAIL x0_read rd1=%h rd2=%h required 0", rd1_b1, rd2_b0);
        end
    endtask

    task automatic test_bypass();
        escribir(7, 32'h0BADF00D);
        rs1 = 7; rs2 = 7;
        escribir(7, 32'hA5A5A5A5);
        checks++;
        if (rd1_b1 !== 32'hA5A5A5A5 || rd2_b1 !== 32'hA5A5A5A5) begin
            errores++; $display("FAIL bypass_on rd1=%h rd2=%h required a5a5a5a5", rd1_b1, rd2_b1);
        end
        checks++;
        if (rd1_b0 !== 32'h0BADF00D || rd2_b0 !== 32'h0BADF00D) begin
            errores++; $display("FAIL bypass_off rd1=%h rd2=%h required 0badf00d", rd1_b0, rd2_b0);
        end
        ciclo();
        checks++;
        if (rd1_b0 !== 32'hA5A5A5A5 || rd2_b1 !== 32'hA5A5A5A5) begin
            errores++; $display("FAIL bypass_after rd1=%h rd2=%h required a5a5a5a5", rd1_b0, rd2_b1);
        end
    endtask

    task automatic test_stall();
        escribir(4, 32'h11);
        rs1 = 4;
        ciclo();
        checks++;
        if (rd1_b1 !== 32'h11) begin
            errores++; $display("FAIL stall_setup rd1=%h required 11", rd1_b1);
        end
        habilitar = 0; we = 1; rd = 4; wd = 32'h22;
        for (int i = 0; i < 3; i++) begin
            ciclo();
            checks++;
            if (rd1_b1 !== 32'h11 || rd1_b0 !== 32'h11) begin
                errores++; $display("FAIL stall_hold cyc=%0d rd1=%h/%h required 11", i, rd1_b1, rd1_b0);
            end
        end
        we = 0; habilitar = 1;
        ciclo();
        checks++;
        if (rd1_b1 !== 32'h22 || rd1_b0 !== 32'h22) begin
            errores++; $display("FAIL stall_release rd1=%h/%h required 22", rd1_b1, rd1_b0);
        end
    endtask

    task automatic test_aleatorio();
        for (int i = 0; i < 400; i++) begin
            habilitar = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1);
            rd  = 5'($urandom_range(0, 31));
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
            wd  = $urandom;
            ciclo();
            checks++;
            if (rd1_b1 !== ref_o[1][0] || rd2_b1 !== ref_o[1][1] ||
                rd1_b0 !== ref_o[0][0] || rd2_b0 !== ref_o[0][1] || listo_b1 !== ref_listo) begin
                errores++;
                $display("FAIL random cyc=%0d got %h %h %h %h l=%b required %h %h %h %h l=%b", i,
                         rd1_b1, rd2_b1, rd1_b0, rd2_b0, listo_b1,
                         ref_o[1][0], ref_o[1][1], ref_o[0][0], ref_o[0][1], ref_listo);
            end
        end
        we = 0; habilitar = 1;
    endtask

    task automatic test_reset_medio();
        escribir(31, 32'h55);
        rs1 = 31; rs2 = 0;
        ciclo();
        checks++;
        if (rd1_b1 !== 32'h55) begin
            errores++; $display("FAIL mid_setup rd1=%h required 55", rd1_b1);
        end
        reset = 1;
        ciclo();
        checks++;
        if (listo_b1 !== 1'b0 || listo_b0 !== 1'b0) begin
            errores++; $display("FAIL mid_listo_drop listo=%b/%b required 0", listo_b1, listo_b0);
        end
        reset = 0;
        for (int i = 1; i <= 9; i++) ciclo();   // next index to clear is 10
        reset = 1; we = 1; rd = 31; wd = 32'h77;
        ciclo();
        checks++;
        if (listo_b1 !== 1'b0 || rd1_b1 !== 32'h0) begin
            errores++; $display("FAIL mid_reset2 listo=%b rd1=%h required 0/0", listo_b1, rd1_b1);
        end
        reset = 0; we = 0;
        for (int i = 1; i <= 31; i++) begin
            ciclo();
            checks++;
            if (listo_b1 !== (i == 31)) begin
                errores++; $display("FAIL mid_sweep edge=%0d listo=%b required %b", i, listo_b1, i == 31);
            end
        end
        rs1 = 31; rs2 = 31;
        ciclo();
        checks++;
        if (rd1_b1 !== 32'h0 || rd2_b0 !== 32'h0) begin
            errores++; $display("FAIL mid_x31_cleared rd1=%h rd2=%h required 0", rd1_b1, rd2_b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        barrido = 1; idx = 1; ref_listo = 0;
        for (int b = 0; b < 2; b++) for (int p = 0; p < 2; p++) ref_o[b][p] = '0;
        #1;
        test_reset();
        test_basico();
        test_x0();
        test_bypass();
        test_stall();
        test_aleatorio();
        test_reset_medio();
        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end
endmodule
